// File: rtl/train_ctrl_pkg.sv
// Shared state and output encodings for the two-train shared-segment controller.
package train_ctrl_pkg;

  typedef enum logic [2:0] {
    ABOUT = 3'd0,
    AIN   = 3'd1,
    BIN   = 3'd2,
    ASTOP = 3'd3,
    BSTOP = 3'd4
  } state_e;

  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_STOP = 2'b00;

  localparam logic SW_A = 1'b0;
  localparam logic SW_B = 1'b1;

endpackage

// File: rtl/train_out_decode.sv
// Combinational state -> switch/direction decode; the top registers the result.
module train_out_decode
  import train_ctrl_pkg::*;
(
  input  state_e     state,
  output logic       sw1,
  output logic       sw2,
  output logic [1:0] da,
  output logic [1:0] db
);

  always_comb begin
    sw1 = SW_A;
    sw2 = SW_A;
    da  = DIR_FWD;
    db  = DIR_FWD;
    case (state)
      ABOUT, AIN: ;
      BSTOP: db = DIR_STOP;
      BIN: begin
        sw1 = SW_B;
        sw2 = SW_B;
      end
      ASTOP: begin
        sw1 = SW_B;
        sw2 = SW_B;
        da  = DIR_STOP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/train_crossing_ctrl.sv
// Moore controller granting the shared track segment to one of two trains at a time.
module train_crossing_ctrl
  import train_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  input  logic       S4,
  output logic       SW1,
  output logic       SW2,
  output logic [1:0] DA,
  output logic [1:0] DB
);

  state_e     state_q, state_d;
  logic       sw1_q, sw1_d;
  logic       sw2_q, sw2_d;
  logic [1:0] da_q, da_d;
  logic [1:0] db_q, db_d;

  always_comb begin
    state_d = ABOUT;
    case (state_q)
      ABOUT: begin
        if (S1)      state_d = AIN;
        else if (S2) state_d = BIN;
        else         state_d = ABOUT;
      end
      AIN: begin
        if (S4 && S2) state_d = BIN;
        else if (S4)  state_d = ABOUT;
        else if (S2)  state_d = BSTOP;
        else          state_d = AIN;
      end
      BSTOP: state_d = S4 ? BIN : BSTOP;
      BIN: begin
        if (S3 && S1) state_d = AIN;
        else if (S3)  state_d = ABOUT;
        else if (S1)  state_d = ASTOP;
        else          state_d = BIN;
      end
      ASTOP: state_d = S3 ? AIN : ASTOP;
      default: state_d = ABOUT;
    endcase
  end

  // Decoding the next state lets the outputs be registered yet still follow a sensor in one edge.
  train_out_decode u_decode (
    .state (state_d),
    .sw1   (sw1_d),
    .sw2   (sw2_d),
    .da    (da_d),
    .db    (db_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ABOUT;
      sw1_q   <= SW_A;
      sw2_q   <= SW_A;
      da_q    <= DIR_FWD;
      db_q    <= DIR_FWD;
    end else begin
      state_q <= state_d;
      sw1_q   <= sw1_d;
      sw2_q   <= sw2_d;
      da_q    <= da_d;
      db_q    <= db_d;
    end
  end

  assign SW1 = sw1_q;
  assign SW2 = sw2_q;
  assign DA  = da_q;
  assign DB  = db_q;

endmodule

// File: tb/tb_train_crossing_ctrl.sv
// Scenario bench for train_crossing_ctrl: each step queues its expected outputs, then checks after the edge.
module tb_train_crossing_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       S1 = 1'b0, S2 = 1'b0, S3 = 1'b0, S4 = 1'b0;
  logic       SW1, SW2;
  logic [1:0] DA, DB;

  int n_checks = 0;
  int n_pass   = 0;
  logic mon_en = 1'b0;
  logic [5:0] sb [$];

  // Expected {SW1,SW2,DA,DB} per controller situation.
  localparam logic [5:0] O_FREE  = 6'b00_01_01;
  localparam logic [5:0] O_BSTOP = 6'b00_01_00;
  localparam logic [5:0] O_BIN   = 6'b11_01_01;
  localparam logic [5:0] O_ASTOP = 6'b11_00_01;

  // Stimulus {reset,S1,S2,S3,S4}.
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_RST  = 5'b10000;
  localparam logic [4:0] I_S1   = 5'b01000;
  localparam logic [4:0] I_S2   = 5'b00100;
  localparam logic [4:0] I_S3   = 5'b00010;
  localparam logic [4:0] I_S4   = 5'b00001;

  train_crossing_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .S1    (S1),
    .S2    (S2),
    .S3    (S3),
    .S4    (S4),
    .SW1   (SW1),
    .SW2   (SW2),
    .DA    (DA),
    .DB    (DB)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (DA == 2'b00 && DB == 2'b00)
        $display("FAIL both_stopped t=%0t: DA=%b DB=%b, required not both 00", $time, DA, DB);
      else
        n_pass++;
      n_checks++;
      if (SW1 !== SW2)
        $display("FAIL switch_pair t=%0t: SW1=%b SW2=%b, required equal", $time, SW1, SW2);
      else
        n_pass++;
    end
  end

  task automatic drive_step(input logic [4:0] in, input logic [5:0] exp);
    {reset, S1, S2, S3, S4} = in;
    sb.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] st [4] = '{{I_RST, O_FREE}, {I_NONE, O_FREE}, {I_NONE, O_FREE}, {I_NONE, O_FREE}};
    logic [5:0] exp, obs;
    for (int i = 0; i < $size(st); i++) begin
      drive_step(st[i][10:6], st[i][5:0]);
      exp = sb.pop_front();
      obs = {SW1, SW2, DA, DB};
      n_checks++;
      if (obs !== exp) $display("FAIL reset step %0d: got %b required %b", i, obs, exp);
      else n_pass++;
      mon_en = 1'b1;
    end
  endtask

  task automatic test_handoff();
    logic [10:0] st [5] = '{{I_S1, O_FREE}, {I_S2, O_BSTOP}, {I_S4, O_BIN},
                            {I_S3, O_FREE}, {I_NONE, O_FREE}};
    logic [5:0] exp, obs;
    for (int i = 0; i < $size(st); i++) begin
      drive_step(st[i][10:6], st[i][5:0]);
      exp = sb.pop_front();
      obs = {SW1, SW2, DA, DB};
      n_checks++;
      if (obs !== exp) $display("FAIL handoff step %0d: got %b required %b", i, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_mirror();
    logic [10:0] st [5] = '{{I_S2, O_BIN}, {I_S1, O_ASTOP}, {I_S3, O_FREE},
                            {I_S4, O_FREE}, {I_NONE, O_FREE}};
    logic [5:0] exp, obs;
    for (int i = 0; i < $size(st); i++) begin
      drive_step(st[i][10:6], st[i][5:0]);
      exp = sb.pop_front();
      obs = {SW1, SW2, DA, DB};
      n_checks++;
      if (obs !== exp) $display("FAIL mirror step %0d: got %b required %b", i, obs, exp);
      else n_pass++;
    end
  endtask

  // Simultaneous requests, then the combined leave-and-request paths in AIN and BIN.
  task automatic test_simultaneous();
    logic [10:0] st [9] = '{{I_S1 | I_S2, O_FREE}, {I_S2, O_BSTOP}, {I_S4, O_BIN},
                            {I_S3, O_FREE},
                            {I_S1, O_FREE}, {I_S2 | I_S4, O_BIN}, {I_S3 | I_S1, O_FREE},
                            {I_S4, O_FREE}, {I_NONE, O_FREE}};
    logic [5:0] exp, obs;
    for (int i = 0; i < $size(st); i++) begin
      drive_step(st[i][10:6], st[i][5:0]);
      exp = sb.pop_front();
      obs = {SW1, SW2, DA, DB};
      n_checks++;
      if (obs !== exp) $display("FAIL simultaneous step %0d: got %b required %b", i, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] st [10] = '{{I_S1, O_FREE}, {I_S2, O_BSTOP}, {I_RST | I_S2, O_FREE},
                             {I_S2, O_BIN}, {I_S3, O_FREE},
                             {I_S2, O_BIN}, {I_S1, O_ASTOP}, {I_RST | I_S1, O_FREE},
                             {I_S1, O_FREE}, {I_S4, O_FREE}};
    logic [5:0] exp, obs;
    for (int i = 0; i < $size(st); i++) begin
      drive_step(st[i][10:6], st[i][5:0]);
      exp = sb.pop_front();
      obs = {SW1, SW2, DA, DB};
      n_checks++;
      if (obs !== exp) $display("FAIL reset_mid step %0d: got %b required %b", i, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_ignored();
    logic [10:0] st [13] = '{{I_S1, O_FREE}, {I_S3, O_FREE}, {I_S1 | I_S3, O_FREE},
                             {I_S4, O_FREE},
                             {I_S2, O_BIN}, {I_S4, O_BIN}, {I_S2 | I_S4, O_BIN},
                             {I_S3, O_FREE},
                             {I_S1, O_FREE}, {I_S2, O_BSTOP}, {I_S1 | I_S2 | I_S3, O_BSTOP},
                             {I_S4, O_BIN}, {I_S3, O_FREE}};
    logic [5:0] exp, obs;
    for (int i = 0; i < $size(st); i++) begin
      drive_step(st[i][10:6], st[i][5:0]);
      exp = sb.pop_front();
      obs = {SW1, SW2, DA, DB};
      n_checks++;
      if (obs !== exp) $display("FAIL ignored step %0d: got %b required %b", i, obs, exp);
      else n_pass++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_handoff();
    test_mirror();
    test_simultaneous();
    test_reset_mid();
    test_ignored();
    mon_en = 1'b0;
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/train_crossing_ctrl.md
Name: train_crossing_ctrl

Overview:
- Moore-style controller for two model trains, A and B, each on its own loop; the loops share one common track segment.
- Four level-sensitive track sensors are sampled on each rising clock edge. The block sets two track switches and drives a 2-bit direction/run command per train.
- Only one train may occupy the shared segment. The second arriving train is stopped until the first one leaves.
- Top-level block of the train-control design; its outputs drive the track hardware directly.

Parameters:
- None. All encodings are fixed constants in the shared package.

Ports:
- clk    input   1  system clock; all state changes on the rising edge.
- reset  input   1  synchronous, active-high reset.
- S1     input   1  train A is approaching the shared segment (requests entry).
- S2     input   1  train B is approaching the shared segment (requests entry).
- S3     input   1  train B is leaving the shared segment.
- S4     input   1  train A is leaving the shared segment.
- SW1    output  1  entry switch: 0 = routed for A, 1 = routed for B.
- SW2    output  1  exit switch: 0 = routed for A, 1 = routed for B.
- DA     output  2  train A command: 2'b01 = run forward, 2'b00 = stop; 2'b10 and 2'b11 are never driven.
- DB     output  2  train B command, same encoding as DA.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous, active-high, and dominates all sensor inputs.
- Reset state is ABOUT. Reset output values: SW1=0, SW2=0, DA=01, DB=01.
- State register: 5 states: ABOUT, AIN, BIN, ASTOP, BSTOP.
- Output timing: all outputs are registered and decoded from state only (Moore). A sensor change is visible on the outputs after exactly 1 rising edge.
- Sensors are level-sensitive. A held sensor is re-evaluated every cycle.
- ABOUT (segment free; SW=00, DA=01, DB=01):
  - S1 -> AIN.
  - else S2 -> BIN.
  - S1 and S2 together: A has priority -> AIN. B's held S2 then produces BSTOP on the next edge.
- AIN (A on segment; SW=00, DA=01, DB=01):
  - S4 and S2 together -> BIN.
  - else S4 -> ABOUT.
  - else S2 -> BSTOP.
- BSTOP (A on segment, B waiting; SW=00, DA=01, DB=00):
  - S4 -> BIN.
  - otherwise stay.
- BIN (B on segment; SW=11, DA=01, DB=01):
  - S3 and S1 together -> AIN.
  - else S3 -> ABOUT.
  - else S1 -> ASTOP.
- ASTOP (B on segment, A waiting; SW=11, DA=00, DB=01):
  - S3 -> AIN.
  - otherwise stay.
- Sensor relevance: sensors not listed for a state are ignored in that state. Spurious S3 in AIN and S4 in BIN have no effect.
- Illegal or unreachable state encodings recover to ABOUT on the next edge, with ABOUT outputs.
- Reset asserted mid-operation, in any state, forces ABOUT and its outputs on that edge. The stopped train restarts.
- Invariant: DA and DB are never both 00.
- Invariant: SW1 always equals SW2.

Decomposition:
- Shared package `train_ctrl_pkg` holds:
  - state enum (ABOUT, AIN, BIN, ASTOP, BSTOP);
  - direction constants DIR_FWD=2'b01, DIR_STOP=2'b00;
  - switch constants SW_A=1'b0, SW_B=1'b1.
- One sub-module, `train_out_decode`: combinational state -> {SW1, SW2, DA, DB} decoder.
- Outputs are registered in the top module.

Test Plan:
- Reset, all sensors 0, one edge -> state ABOUT; SW1=0, SW2=0, DA=01, DB=01. Hold 3 idle cycles -> outputs unchanged.
- Full hand-off:
  - S1=1, edge -> DA=01, DB=01, SW=00.
  - S1=0 S2=1, edge -> DB=00, DA=01, SW=00.
  - S2=0 S4=1, edge -> DB=01, SW1=1, SW2=1.
  - S4=0 S3=1, edge -> DA=01, DB=01, SW=00.
- Mirror case:
  - from ABOUT: S2, edge -> SW=11.
  - S1, edge -> DA=00, DB=01.
  - S3, edge -> SW=00, DA=01.
  - S4, edge -> ABOUT, all run.
- Simultaneous S1=S2=1 from ABOUT: edge 1 -> AIN (SW=00, all run). Edge 2, S2 still high -> DB=00.
- Reset mid-operation: in BSTOP assert reset with S2=1 -> next edge DB=01, SW=00, DA=01. Deassert reset with S2=1 -> next edge BIN, SW=11.
- Ignored sensors: in AIN pulse S3, and in BIN pulse S4 -> no output change. Across every cycle of all tests, DA and DB are never both 00.
